branch_predictor_btb: RTL and testbench

Dynamic branch predictor for the pipelined RISC-V core: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. It replaces the static predict-not-taken scheme, where every taken branch resolved in MEM causes a flush.
- IF looks up the fetch PC in the same cycle.
- The resolution stage writes the outcome back.
- The block raises mispredict/redirect so the PC mux and flush logic recover.

---
 rtl/btb_pkg.sv | 21 ++
 rtl/btb_sat_ctr.sv | 20 ++
 rtl/branch_predictor_btb.sv | 100 ++++++++++
 tb/tb_branch_predictor_btb.sv | 134 +++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared types, counter encodings and saturating helpers for the BTB
package btb_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam int BTB_XLEN     = 64;
  localparam int BTB_TAG_BITS = 12;
  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [BTB_XLEN-1:0]     target;
    logic [1:0]              ctr;
  } btb_entry_t;
  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/btb_sat_ctr.sv
// btb_sat_ctr: 2-bit saturating up/down counter, load has priority over inc/dec
// Ports: clk, rst (async, resets to weakly-not-taken), load_i/load_val_i, inc_i, dec_i, ctr_o
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] ctr_o
);
  logic [1:0] ctr_q, ctr_d;
  always_comb ctr_d = load_i ? load_val_i : inc_i ? sat_inc2(ctr_q) : dec_i ? sat_dec2(ctr_q) : ctr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ctr_q <= WNT;
    else     ctr_q <= ctr_d;
  assign ctr_o = ctr_q;
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit counters, mispredict detection and statistics
// Ports: clk/reset (async high), clear (sync invalidate), if_pc -> pred_hit/pred_taken/pred_target,
//        upd_* resolution inputs -> mispredict/redirect_pc, stat_branches/stat_mispredicts
module branch_predictor_btb
  import btb_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 12,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];
  logic [XLEN-1:0]     tgt_d [ENTRIES];
  logic [1:0]          ctr   [ENTRIES];
  logic [STAT_W-1:0]   br_q, br_d, mp_q, mp_d;
  logic [IDX_W-1:0]    l_idx, u_idx;
  logic [TAG_BITS-1:0] l_tag, u_tag;
  logic                u_hit, upd_br, br_mp;
  assign l_idx = if_pc[IDX_W+1:2];
  assign l_tag = if_pc[IDX_W+TAG_BITS+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_BITS+1:IDX_W+2];
  assign pred_hit    = valid_q[l_idx] & (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit & ctr[l_idx][1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : if_pc + XLEN'(4);
  assign u_hit  = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign upd_br = upd_valid & upd_is_branch;
  assign br_mp  = (upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target));
  // A non-branch that was predicted taken is an alias hit on someone else's entry
  assign mispredict  = upd_valid & (upd_is_branch ? br_mp : upd_pred_taken);
  assign redirect_pc = (upd_is_branch & upd_taken) ? upd_target : upd_pc + XLEN'(4);
  // Taken updates rewrite tag/target for both hit and allocate; on a hit the tag is unchanged
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (clear) valid_d = '0;
    else if (upd_br & upd_taken) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      tgt_d[u_idx]   = upd_target;
    end else if (upd_valid & ~upd_is_branch & u_hit) valid_d[u_idx] = 1'b0;
  end
  assign br_d = (upd_br & ~&br_q) ? br_q + STAT_W'(1) : br_q;
  assign mp_d = (mispredict & ~&mp_q) ? mp_q + STAT_W'(1) : mp_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0;
      br_q    <= '0;
      mp_q    <= '0;
      for (int k = 0; k < ENTRIES; k++) begin
        tag_q[k] <= '0;
        tgt_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd_br & (u_idx == IDX_W'(i));
    btb_sat_ctr u_ctr (
      .clk        (clk),
      .rst        (reset),
      .load_i     (clear | (sel & ~u_hit & upd_taken)),
      .load_val_i (clear ? WNT : WT),
      .inc_i      (sel & u_hit & upd_taken),
      .dec_i      (sel & u_hit & ~upd_taken),
      .ctr_o      (ctr[i])
    );
  end
  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed scoreboard bench for the BTB (4-bit statistics build)
module tb_branch_predictor_btb;
  typedef struct packed {
    logic v, br, tk, ptk;
    logic [63:0] pc, tgt, ptgt;
  } upd_t;
  typedef struct {
    string       nm;
    logic        hit, tk;
    logic [63:0] tgt;
    logic        mp;
    logic [63:0] rd;
    logic [3:0]  sb, sm;
  } exp_t;
  logic        clk = 0, reset = 1, clear = 0;
  logic [63:0] if_pc = 0;
  logic        pred_hit, pred_taken, mispredict;
  logic [63:0] pred_target, redirect_pc;
  logic        upd_valid = 0, upd_is_branch = 0, upd_taken = 0, upd_pred_taken = 0;
  logic [63:0] upd_pc = 0, upd_target = 0, upd_pred_target = 0;
  logic [3:0]  stat_branches, stat_mispredicts;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [3:0]  sb = 0, sm = 0;
  event        sample_ev;
  upd_t        none;
  branch_predictor_btb #(.XLEN(64), .ENTRIES(16), .TAG_BITS(12), .STAT_W(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );
  always #5 clk = ~clk;
  function automatic upd_t mk(input logic v, br, tk, ptk, input logic [63:0] pc, tgt, ptgt);
    upd_t u;
    u.v = v; u.br = br; u.tk = tk; u.ptk = ptk; u.pc = pc; u.tgt = tgt; u.ptgt = ptgt;
    return u;
  endfunction
  task automatic chk(input string nm, input string f, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, a, e);
    end
  endtask
  initial forever begin
    @(negedge clk or sample_ev);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "hit", {63'b0, pred_hit}, {63'b0, e.hit});
      chk(e.nm, "taken", {63'b0, pred_taken}, {63'b0, e.tk});
      chk(e.nm, "target", pred_target, e.tgt);
      chk(e.nm, "mispredict", {63'b0, mispredict}, {63'b0, e.mp});
      if (e.mp) chk(e.nm, "redirect", redirect_pc, e.rd);
      chk(e.nm, "stat_br", {60'b0, stat_branches}, {60'b0, e.sb});
      chk(e.nm, "stat_mp", {60'b0, stat_mispredicts}, {60'b0, e.sm});
    end
  end
  task automatic push(input string nm, input logic eh, et, input logic [63:0] etg,
                      input logic emp, input logic [63:0] erd);
    exp_t e;
    e.nm = nm; e.hit = eh; e.tk = et; e.tgt = etg; e.mp = emp; e.rd = erd; e.sb = sb; e.sm = sm;
    q.push_back(e);
  endtask
  task automatic step(input logic [63:0] pc, input upd_t u, input logic clr, input logic eh, et,
                      input logic [63:0] etg, input logic emp, input logic [63:0] erd, input string nm);
    if_pc = pc; clear = clr;
    upd_valid = u.v; upd_is_branch = u.br; upd_taken = u.tk; upd_pred_taken = u.ptk;
    upd_pc = u.pc; upd_target = u.tgt; upd_pred_target = u.ptgt;
    push(nm, eh, et, etg, emp, erd);
    @(posedge clk); #1;
    if (u.v && u.br && sb != 4'hF) sb++;
    if (emp && sm != 4'hF) sm++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    none = mk(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    step(64'h100, none, 0, 0, 0, 64'h104, 0, 0, "reset");
    step(64'h40, mk(1,1,1,0,64'h40,64'h80,0), 0, 0, 0, 64'h44, 1, 64'h80, "alloc");
    step(64'h40, none, 0, 1, 1, 64'h80, 0, 0, "hit");
    step(64'h40, mk(1,1,0,1,64'h40,0,64'h80), 0, 1, 1, 64'h80, 1, 64'h44, "nt_same_cycle");
    step(64'h40, none, 0, 1, 0, 64'h44, 0, 0, "hyst_nt");
    step(64'h40, mk(1,1,1,0,64'h40,64'h80,64'h80), 0, 1, 0, 64'h44, 1, 64'h80, "tk1");
    for (int i = 0; i < 3; i++)
      step(64'h40, mk(1,1,1,1,64'h40,64'h80,64'h80), 0, 1, 1, 64'h80, 0, 0, "tk_sat");
    step(64'h40, mk(1,1,0,1,64'h40,0,64'h80), 0, 1, 1, 64'h80, 1, 64'h44, "nt_from_st");
    step(64'h40, none, 0, 1, 1, 64'h80, 0, 0, "still_taken");
    step(64'h40, mk(1,1,1,1,64'h40,64'hC0,64'h80), 0, 1, 1, 64'h80, 1, 64'hC0, "tgt_mismatch");
    step(64'h40, none, 0, 1, 1, 64'hC0, 0, 0, "new_target");
    step(64'h40, mk(1,1,1,0,64'h80,64'h200,0), 0, 1, 1, 64'hC0, 1, 64'h200, "evict");
    step(64'h40, none, 0, 0, 0, 64'h44, 0, 0, "evicted_miss");
    step(64'h80, mk(1,0,0,1,64'h80,0,64'h200), 0, 1, 1, 64'h200, 1, 64'h84, "alias");
    step(64'h80, none, 0, 0, 0, 64'h84, 0, 0, "alias_cleared");
    step(64'h100, mk(1,0,0,0,64'h100,0,0), 0, 0, 0, 64'h104, 0, 0, "nonbranch_ok");
    step(64'h44, mk(1,1,0,0,64'h44,0,0), 0, 0, 0, 64'h48, 0, 0, "nt_miss");
    step(64'h44, mk(1,1,1,0,64'h40,64'h80,0), 0, 0, 0, 64'h48, 1, 64'h80, "no_alloc_nt");
    step(64'h48, mk(1,1,1,0,64'h48,64'h300,0), 1, 0, 0, 64'h4C, 1, 64'h300, "clear_upd");
    step(64'h48, none, 0, 0, 0, 64'h4C, 0, 0, "clear_no_alloc");
    step(64'h40, none, 0, 0, 0, 64'h44, 0, 0, "clear_invalidated");
    step(64'hFFFF_FFFF_FFFF_FFFC, mk(1,0,0,1,64'hFFFF_FFFF_FFFF_FFFC,0,64'h10), 0, 0, 0, 64'h0, 1, 64'h0, "wrap");
    for (int i = 0; i < 20; i++)
      step(64'h104, mk(1,1,0,0,64'h104,0,0), 0, 0, 0, 64'h108, 0, 0, "br_sat");
    for (int i = 0; i < 10; i++)
      step(64'h8, mk(1,0,0,1,64'h8,0,0), 0, 0, 0, 64'hC, 1, 64'hC, "mp_sat");
    step(64'h8, none, 0, 0, 0, 64'hC, 0, 0, "stats_held");
    step(64'h40, mk(1,1,1,0,64'h40,64'h80,0), 0, 0, 0, 64'h44, 1, 64'h80, "pre_reset_alloc");
    if_pc = 64'h40; upd_valid = 0; upd_is_branch = 0; upd_taken = 0; upd_pred_taken = 0;
    push("pre_reset", 1, 1, 64'h80, 0, 0);
    ->sample_ev;
    #1 reset = 1;
    sb = 0; sm = 0;
    #1 push("async_reset", 0, 0, 64'h44, 0, 0);
    ->sample_ev;
    @(posedge clk); #1 reset = 0;
    step(64'h40, none, 0, 0, 0, 64'h44, 0, 0, "after_reset");
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
